// File: rtl/mem_io_responder.sv
// Memory-bus responder for the eLC-3 datapath: SRAM with wait states plus the
// keyboard / display / machine-control device page. One access per MIO_EN assertion.
module mem_io_responder #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] Address,
    input  logic [15:0] Data_In,
    output logic [15:0] Data_Out,
    output logic        R,
    output logic [15:0] SRAM_Addr,
    output logic [15:0] SRAM_WData,
    input  logic [15:0] SRAM_RData,
    output logic        SRAM_CE,
    output logic        SRAM_WE,
    input  logic [7:0]  KB_Data,
    input  logic        KB_Valid,
    output logic [7:0]  DISP_Data,
    output logic        DISP_Valid,
    input  logic        DISP_Ready,
    output logic        Run
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [15:0] DEV_BASE = 16'hFE00;
    localparam logic [15:0] A_KBSR   = 16'hFE00;
    localparam logic [15:0] A_KBDR   = 16'hFE02;
    localparam logic [15:0] A_DSR    = 16'hFE04;
    localparam logic [15:0] A_DDR    = 16'hFE06;
    localparam logic [15:0] A_MCR    = 16'hFFFE;

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        r_q, r_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_wdata_q, sram_wdata_d;
    logic        sram_ce_q, sram_ce_d;
    logic        sram_we_q, sram_we_d;
    logic        kbsr_q, kbsr_d;
    logic [7:0]  kbdr_q, kbdr_d;
    logic        disp_valid_q, disp_valid_d;
    logic [7:0]  disp_data_q, disp_data_d;
    logic [15:0] mcr_q, mcr_d;

    logic        dev_acc, dev_rd, dev_wr;
    logic [15:0] dev_rdata;

    always_comb begin
        dev_acc = (state_q == IDLE) && MIO_EN && (Address >= DEV_BASE);
        dev_rd  = dev_acc && !R_W;
        dev_wr  = dev_acc && R_W;
        case (Address)
            A_KBSR:  dev_rdata = {kbsr_q, 15'd0};
            A_KBDR:  dev_rdata = {8'h00, kbdr_q};
            A_DSR:   dev_rdata = {~disp_valid_q, 15'd0};
            A_DDR:   dev_rdata = {8'h00, disp_data_q};
            A_MCR:   dev_rdata = mcr_q;
            default: dev_rdata = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_ce_d    = sram_ce_q;
        sram_we_d    = sram_we_q;
        kbsr_d       = kbsr_q;
        kbdr_d       = kbdr_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        mcr_d        = mcr_q;

        case (state_q)
            IDLE: begin
                if (MIO_EN) begin
                    if (Address < DEV_BASE) begin
                        sram_ce_d    = 1'b1;
                        sram_we_d    = R_W;
                        sram_addr_d  = Address;
                        sram_wdata_d = Data_In;
                        cnt_d        = '0;
                        state_d      = ACCESS;
                    end else begin
                        if (!R_W) dout_d = dev_rdata;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WS_CNT) begin
                    if (!sram_we_q) dout_d = SRAM_RData;
                    sram_ce_d = 1'b0;
                    sram_we_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = MIO_EN ? RELEASE : IDLE;
            default: if (!MIO_EN) state_d = IDLE;
        endcase

        // A keyboard strobe on the same edge as a KBDR read wins: the read
        // already took the old character, the new one stays pending.
        if (dev_rd && (Address == A_KBDR)) kbsr_d = 1'b0;
        if (KB_Valid) begin
            kbdr_d = KB_Data;
            kbsr_d = 1'b1;
        end

        if (disp_valid_q && DISP_Ready) disp_valid_d = 1'b0;
        if (dev_wr && (Address == A_DDR) && !disp_valid_q) begin
            disp_valid_d = 1'b1;
            disp_data_d  = Data_In[7:0];
        end

        if (dev_wr && (Address == A_MCR)) mcr_d = Data_In;

        r_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            r_q          <= 1'b0;
            dout_q       <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            kbsr_q       <= 1'b0;
            kbdr_q       <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            mcr_q        <= 16'h8000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            r_q          <= r_d;
            dout_q       <= dout_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_ce_q    <= sram_ce_d;
            sram_we_q    <= sram_we_d;
            kbsr_q       <= kbsr_d;
            kbdr_q       <= kbdr_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            mcr_q        <= mcr_d;
        end
    end

    assign Data_Out   = dout_q;
    assign R          = r_q;
    assign SRAM_Addr  = sram_addr_q;
    assign SRAM_WData = sram_wdata_q;
    assign SRAM_CE    = sram_ce_q;
    assign SRAM_WE    = sram_we_q;
    assign DISP_Data  = disp_data_q;
    assign DISP_Valid = disp_valid_q;
    assign Run        = mcr_q[15];

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus random transactions
// compared against a register-level model of the memory map.
module tb_mem_io_responder;

    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        MIO_EN = 1'b0;
    logic        R_W = 1'b0;
    logic [15:0] Address = '0;
    logic [15:0] Data_In = '0;
    logic [15:0] Data_Out;
    logic        R;
    logic [15:0] SRAM_Addr, SRAM_WData, SRAM_RData;
    logic        SRAM_CE, SRAM_WE;
    logic [7:0]  KB_Data = '0;
    logic        KB_Valid = 1'b0;
    logic [7:0]  DISP_Data;
    logic        DISP_Valid;
    logic        DISP_Ready = 1'b0;
    logic        Run;

    mem_io_responder #(.WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W),
        .Address(Address), .Data_In(Data_In), .Data_Out(Data_Out), .R(R),
        .SRAM_Addr(SRAM_Addr), .SRAM_WData(SRAM_WData), .SRAM_RData(SRAM_RData),
        .SRAM_CE(SRAM_CE), .SRAM_WE(SRAM_WE),
        .KB_Data(KB_Data), .KB_Valid(KB_Valid),
        .DISP_Data(DISP_Data), .DISP_Valid(DISP_Valid), .DISP_Ready(DISP_Ready),
        .Run(Run)
    );

    always #5 Clk = ~Clk;

    // SRAM behind the port: asynchronous read, synchronous write.
    logic [15:0] sram [0:65535];
    assign SRAM_RData = sram[SRAM_Addr];
    always @(posedge Clk) if (SRAM_CE && SRAM_WE) sram[SRAM_Addr] <= SRAM_WData;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model of the architectural state.
    logic [15:0] ref_mem [16];
    logic        m_kbsr, m_dv;
    logic [7:0]  m_kbdr, m_dd;
    logic [15:0] m_mcr, m_dout;

    task automatic model_reset();
        m_kbsr = 0; m_kbdr = '0; m_dv = 0; m_dd = '0; m_mcr = 16'h8000; m_dout = '0;
    endtask

    function automatic logic [15:0] model_dev_read(input logic [15:0] a);
        if (a == 16'hFE00) return m_kbsr ? 16'h8000 : 16'h0000;
        if (a == 16'hFE02) return {8'h00, m_kbdr};
        if (a == 16'hFE04) return m_dv ? 16'h0000 : 16'h8000;
        if (a == 16'hFE06) return {8'h00, m_dd};
        if (a == 16'hFFFE) return m_mcr;
        return 16'h0000;
    endfunction

    task automatic model_access(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                                input logic kb, input logic [7:0] kbc);
        if (a < 16'hFE00) begin
            if (rw) ref_mem[a[3:0]] = wd;
            else    m_dout = ref_mem[a[3:0]];
        end else if (!rw) begin
            m_dout = model_dev_read(a);
            if (a == 16'hFE02) m_kbsr = 0;
        end else begin
            if (a == 16'hFE06 && !m_dv) begin m_dv = 1; m_dd = wd[7:0]; end
            if (a == 16'hFFFE) m_mcr = wd;
        end
        if (kb) begin m_kbsr = 1; m_kbdr = kbc; end
    endtask

    task automatic do_access(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                             input int hold, input logic kb, input logic [7:0] kbc,
                             output int lat, output int ce_cyc, output int extra_r);
        @(negedge Clk);
        MIO_EN = 1; R_W = rw; Address = a; Data_In = wd;
        if (kb) begin KB_Valid = 1; KB_Data = kbc; end
        lat = 0; ce_cyc = 0; extra_r = 0;
        while (lat < 40) begin
            @(posedge Clk); #1;
            KB_Valid = 0;
            lat++;
            if (SRAM_CE) ce_cyc++;
            if (R) break;
        end
        repeat (hold) begin @(posedge Clk); #1; if (R) extra_r++; end
        @(negedge Clk); MIO_EN = 0;
        repeat (2) begin @(posedge Clk); #1; if (R) extra_r++; end
    endtask

    task automatic run_txn(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                           input int hold, input logic kb, input logic [7:0] kbc);
        int lat, ce_cyc, extra_r;
        bit dev;
        dev = (a >= 16'hFE00);
        model_access(rw, a, wd, kb, kbc);
        do_access(rw, a, wd, hold, kb, kbc, lat, ce_cyc, extra_r);
        check_val("r_latency", 32'(lat), dev ? 32'd1 : 32'(WS + 2));
        check_val("ce_cycles", 32'(ce_cyc), dev ? 32'd0 : 32'(WS + 1));
        check_val("single_r", 32'(extra_r), 32'd0);
        check_val("data_out", {16'h0, Data_Out}, {16'h0, m_dout});
        check_val("run", {31'h0, Run}, {31'h0, m_mcr[15]});
        check_val("disp_valid", {31'h0, DISP_Valid}, {31'h0, m_dv});
        check_val("disp_data", {24'h0, DISP_Data}, {24'h0, m_dd});
    endtask

    task automatic kb_pulse(input logic [7:0] c);
        @(negedge Clk); KB_Valid = 1; KB_Data = c;
        @(negedge Clk); KB_Valid = 0;
        m_kbsr = 1; m_kbdr = c;
    endtask

    task automatic ready_pulse();
        @(negedge Clk); DISP_Ready = 1;
        @(negedge Clk); DISP_Ready = 0;
        m_dv = 0;
    endtask

    initial begin
        int rc;
        logic [15:0] a;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1;
        #1;
        check_val("rst_r", {31'h0, R}, 32'h0);
        check_val("rst_ce", {31'h0, SRAM_CE}, 32'h0);
        check_val("rst_we", {31'h0, SRAM_WE}, 32'h0);
        check_val("rst_dout", {16'h0, Data_Out}, 32'h0);
        check_val("rst_saddr", {16'h0, SRAM_Addr}, 32'h0);
        check_val("rst_swdata", {16'h0, SRAM_WData}, 32'h0);
        check_val("rst_dvalid", {31'h0, DISP_Valid}, 32'h0);
        check_val("rst_ddata", {24'h0, DISP_Data}, 32'h0);
        check_val("rst_run", {31'h0, Run}, 32'h1);
        run_txn(0, 16'hFE04, '0, 0, 0, '0);
        check_val("rst_dsr", {16'h0, Data_Out}, 32'h8000);
        run_txn(0, 16'hFE00, '0, 0, 0, '0);
        check_val("rst_kbsr", {16'h0, Data_Out}, 32'h0000);

        // Populate the SRAM window used by the random phase.
        for (int unsigned i = 0; i < 16; i++)
            run_txn(1, 16'h3000 + 16'(i), 16'($urandom), 0, 0, '0);

        run_txn(1, 16'h3000, 16'h1234, 0, 0, '0);
        run_txn(0, 16'h3000, '0, 10, 0, '0);
        check_val("sram_readback", {16'h0, Data_Out}, 32'h1234);

        kb_pulse(8'h41);
        run_txn(0, 16'hFE00, '0, 0, 0, '0);
        check_val("kbsr_set", {16'h0, Data_Out}, 32'h8000);
        run_txn(0, 16'hFE02, '0, 0, 0, '0);
        check_val("kbdr", {16'h0, Data_Out}, 32'h0041);
        run_txn(0, 16'hFE00, '0, 0, 0, '0);
        check_val("kbsr_clr", {16'h0, Data_Out}, 32'h0000);
        run_txn(0, 16'hFE02, '0, 0, 1, 8'h42);
        check_val("kbdr_race_old", {16'h0, Data_Out}, 32'h0041);
        run_txn(0, 16'hFE00, '0, 0, 0, '0);
        check_val("kbsr_race", {16'h0, Data_Out}, 32'h8000);

        run_txn(1, 16'hFE06, 16'h0058, 0, 0, '0);
        check_val("disp_data_58", {24'h0, DISP_Data}, 32'h58);
        run_txn(0, 16'hFE04, '0, 0, 0, '0);
        check_val("dsr_busy", {16'h0, Data_Out}, 32'h0000);
        run_txn(1, 16'hFE06, 16'h0059, 0, 0, '0);
        check_val("ddr_dropped", {24'h0, DISP_Data}, 32'h58);
        ready_pulse();
        run_txn(0, 16'hFE04, '0, 0, 0, '0);
        check_val("dsr_idle", {16'h0, Data_Out}, 32'h8000);

        run_txn(1, 16'hFFFE, 16'h0000, 0, 0, '0);
        check_val("run_off", {31'h0, Run}, 32'h0);
        run_txn(0, 16'hFE10, '0, 0, 0, '0);
        check_val("unmapped", {16'h0, Data_Out}, 32'h0000);

        for (int n = 0; n < 200; n++) begin
            rc = int'($urandom_range(0, 9));
            case (rc)
                0, 1, 2, 3: begin
                    a = 16'h3000 + 16'($urandom_range(0, 15));
                    run_txn(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 8'($urandom));
                end
                4: run_txn(0, 16'hFE02, '0, 0, 1'($urandom), 8'($urandom));
                5: run_txn(1'($urandom), 16'hFE00, 16'($urandom), 0, 0, '0);
                6: run_txn(1'($urandom), 16'hFE04, 16'($urandom), 1, 0, '0);
                7: run_txn(1'($urandom), 16'hFE06, 16'($urandom), 0, 0, '0);
                8: run_txn(1'($urandom), 16'hFFFE, 16'($urandom), 2, 0, '0);
                default: run_txn(1'($urandom), 16'hFE08 + 16'($urandom_range(0, 200)), 16'($urandom), 0, 0, '0);
            endcase
            if ($urandom_range(0, 3) == 0) kb_pulse(8'($urandom));
            if ($urandom_range(0, 3) == 0) ready_pulse();
        end

        // Reset in the middle of an SRAM read.
        @(negedge Clk);
        MIO_EN = 1; R_W = 0; Address = 16'h3005;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check_val("mid_ce_high", {31'h0, SRAM_CE}, 32'h1);
        #2 Reset = 0;
        #1;
        check_val("mid_rst_ce", {31'h0, SRAM_CE}, 32'h0);
        check_val("mid_rst_r", {31'h0, R}, 32'h0);
        check_val("mid_rst_dout", {16'h0, Data_Out}, 32'h0);
        check_val("mid_rst_run", {31'h0, Run}, 32'h1);
        MIO_EN = 0;
        model_reset();
        rc = 0;
        repeat (4) begin @(posedge Clk); #1; if (R) rc++; end
        check_val("mid_rst_no_r", 32'(rc), 32'd0);
        @(negedge Clk); Reset = 1;
        run_txn(0, 16'h3005, '0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the eLC-3 datapath's memory bus. It accepts one read or write per `MIO_EN` assertion, decodes the address into SRAM space or the memory-mapped device page, and returns read data with a one-cycle ready pulse `R`. SRAM accesses take a configurable number of wait states. The device page holds the keyboard, display and machine-control registers.

## Interface
**Parameters**
- `WAIT_STATES`, 2: extra SRAM cycles per access, range 0–15.

**Ports**
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `MIO_EN`  in  1  access request from the datapath; held high until `R` is seen.
- `R_W`  in  1  1 = write, 0 = read; sampled with `MIO_EN`.
- `Address`  in  16  word address, driven from the datapath's MAR.
- `Data_In`  in  16  write data, driven from the datapath's MDR.
- `Data_Out`  out  16  read data to the datapath's MDR mux.
- `R`  out  1  ready pulse, high for exactly one cycle per access.
- `SRAM_Addr`  out  16  SRAM address.
- `SRAM_WData`  out  16  SRAM write data.
- `SRAM_RData`  in  16  SRAM read data.
- `SRAM_CE`  out  1  SRAM chip enable.
- `SRAM_WE`  out  1  SRAM write enable.
- `KB_Data`  in  8  keyboard character.
- `KB_Valid`  in  1  one-cycle strobe that accompanies `KB_Data`.
- `DISP_Data`  out  8  display character.
- `DISP_Valid`  out  1  display handshake valid.
- `DISP_Ready`  in  1  display handshake ready.
- `Run`  out  1  `MCR[15]`, the CPU clock-enable.

## Operation
**Address map**
- Addresses below xFE00 go to SRAM.
- xFE00 KBSR: only bit 15 is meaningful (character ready).
- xFE02 KBDR: `{8'h00, char}`.
- xFE04 DSR: bit 15 = display idle.
- xFE06 DDR: display data register.
- xFFFE MCR: all 16 bits read/write.
- Any other address ≥ xFE00 reads x0000; writes to it are ignored.
- Status registers ignore writes: KBSR, KBDR and DSR.

**FSM states:** IDLE, ACCESS, DONE, RELEASE.
- **IDLE, `MIO_EN` = 1:** latch `Address`, `R_W` and `Data_In`.
  - SRAM address: go to ACCESS with wait counter = 0, and register `SRAM_CE` = 1, `SRAM_WE` = `R_W`, `SRAM_Addr`, `SRAM_WData`.
  - Device address: perform the register access on this same edge, register `Data_Out` (reads only), go to DONE.
- **ACCESS:** hold all SRAM outputs and increment the counter.
  - When counter = `WAIT_STATES`: on read, capture `SRAM_RData` into `Data_Out`; drop `SRAM_CE` and `SRAM_WE`; go to DONE.
- **DONE:** `R` = 1.
  - `MIO_EN` already 0 → IDLE.
  - Otherwise → RELEASE.
- **RELEASE:** wait for `MIO_EN` = 0, then go to IDLE. This enforces exactly one access per assertion.

**Data_Out rules**
- `Data_Out` holds its value until the next read completes.
- Writes leave `Data_Out` unchanged.

**Keyboard**
- `KB_Valid` loads KBDR with `KB_Data` and sets KBSR[15].
- If a character is already pending, the new character overwrites it.
- A read of KBDR clears KBSR[15].
- If `KB_Valid` and a KBDR read land on the same edge: the read returns the old KBDR, then the new character is loaded and KBSR[15] stays 1.

**Display**
- DSR[15] = ~`DISP_Valid`.
- A DDR write while DSR[15] = 1 latches `Data_In[7:0]` into `DISP_Data` and sets `DISP_Valid`.
- A DDR write while busy is dropped.
- `DISP_Valid` clears on the edge where `DISP_Valid` and `DISP_Ready` are both 1.

**MCR**
- A write to MCR updates `Run` = `MCR[15]` on the access edge.

**Reset:** asserting `Reset` at any time, including mid-access, returns all outputs and registers to their reset values immediately.
- FSM → IDLE.
- `R`, `SRAM_CE`, `SRAM_WE`, `DISP_Valid` = 0.
- `Data_Out`, `SRAM_Addr`, `SRAM_WData` = x0000; `DISP_Data` = x00.
- KBSR = KBDR = 0.
- MCR = x8000, so `Run` = 1.

## Timing
- Edge 0 is the edge that samples `MIO_EN` = 1 in IDLE.
- **Device access:** `R` and `Data_Out` are valid in the cycle after edge 0 (latency 1).
- **SRAM access:**
  - `SRAM_CE` is high for `WAIT_STATES`+1 cycles, following edges 0 through `WAIT_STATES`.
  - `SRAM_RData` is sampled at edge `WAIT_STATES`+1.
  - `R` is high after edge `WAIT_STATES`+1 (default: after edge 3).
- `R` is never high for two consecutive cycles.
- A new access is accepted no earlier than one cycle after `MIO_EN` falls.
- `Data_Out` is valid in the cycle in which `R` = 1.

## Test plan
- **Reset values:** release `Reset` → all outputs at reset values, `Run` = 1, DSR reads x8000, KBSR reads x0000.
- **SRAM write then read:** write x1234 to x3000, then read x3000 with default `WAIT_STATES`.
  - `SRAM_CE` is high for exactly 3 cycles per access.
  - `R` goes high after edge 3.
  - The read returns x1234 (SRAM model behind the SRAM port).
  - Holding `MIO_EN` high for 10 cycles yields exactly one `R`.
- **Keyboard:** `KB_Valid` with x41 → KBSR = x8000; read KBDR → x0041, then KBSR = x0000. Pulse `KB_Valid` with x42 on the same edge as a KBDR read → the read returns the old value and KBSR stays x8000.
- **Display handshake:** hold `DISP_Ready` low and write x0058 to DDR → `DISP_Data` = x58, `DISP_Valid` = 1, DSR = x0000.
  - A second DDR write of x0059 is dropped.
  - Raising `DISP_Ready` for 1 cycle → `DISP_Valid` = 0, DSR = x8000.
- **MCR and unmapped space:** write x0000 to xFFFE → `Run` = 0; reading xFE10 returns x0000.
- **Reset mid-access:** assert `Reset` during ACCESS → `SRAM_CE` drops at once with no `R` pulse; a subsequent read completes normally.
